// File: rtl/mrd_pkt_sched.sv
// Two-engine packet scheduler: round-robin input steering plus in-order output selection.
// Optional input idle timeout is built only when MRD_SCHED_TIMEOUT_EN is defined.
//
// state    | meaning
// IN_IDLE  | waiting for a packet start aimed at engine nxt
// IN_FWD   | forwarding beats of the current packet to engine eng_sel
// OUT_IDLE | waiting for src_sop from the engine at the queue head
// OUT_ACT  | head engine is emitting its packet on the shared output
module mrd_pkt_sched #(
  parameter int TMO_W   = 16,
  parameter int TMO_MAX = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_sop,
  input  logic       in_eop,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] eng_ready,
  output logic [1:0] eng_sop,
  output logic [1:0] eng_valid,
  output logic [1:0] eng_eop,
  output logic       eng_sel,
  input  logic [1:0] src_sop,
  input  logic [1:0] src_eop,
  output logic       out_sel,
  output logic [1:0] busy,
  output logic       err_drop,
  output logic       ord_err,
  output logic       tmo
);

  typedef enum logic {IN_IDLE, IN_FWD} in_state_t;
  typedef enum logic {OUT_IDLE, OUT_ACT} out_state_t;

  in_state_t  in_state;
  out_state_t out_state;

  logic       nxt;
  logic       q0, q1;
  logic [1:0] q_cnt;

  logic       q0_n, q1_n;
  logic [1:0] q_cnt_n;
  logic [1:0] busy_n;

  logic in_idle, sop_v, acc, drop, fwd, fwd_eop;
  logic q_empty, ord_ev, h_sop, h_eop, pop, tgt, tmo_hit;

  function automatic logic [1:0] onehot(input logic b);
    return b ? 2'b10 : 2'b01;
  endfunction

  // An out-of-range TMO_MAX for the counter width leaves this marker block in the hierarchy.
  if (TMO_MAX < 1 || TMO_MAX > 2**TMO_W) begin : g_tmo_cfg_bad
  end

  assign in_idle  = (in_state == IN_IDLE);
  assign in_ready = ~rst & in_idle & eng_ready[nxt] & ~busy[nxt] & (q_cnt != 2'd2);

  assign sop_v   = in_sop & in_valid;
  assign acc     = sop_v & in_ready;
  assign drop    = sop_v & ~in_ready;
  // A start seen mid-packet is dropped, never forwarded as a data beat.
  assign fwd     = ~in_idle & in_valid & ~in_sop;
  assign fwd_eop = fwd & in_eop;
  assign tgt     = acc ? nxt : eng_sel;

  assign q_empty = (q_cnt == 2'd0);
  assign out_sel = ~q_empty & q0;
  assign h_sop   = ~q_empty & src_sop[out_sel];
  assign h_eop   = ~q_empty & src_eop[out_sel];
  assign pop     = h_eop & ((out_state == OUT_ACT) | h_sop);
  assign ord_ev  = q_empty ? (|src_sop | |src_eop)
                           : (src_sop[~out_sel] | src_eop[~out_sel]);

`ifdef MRD_SCHED_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO_MAX - 1);

  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_hit = ~in_idle & ~in_valid & (tmo_cnt == '0);

  // Down-counter of remaining idle cycles; reloaded on any input activity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (acc || (!in_idle && in_valid)) begin
      tmo_cnt <= TMO_LOAD;
    end else if (in_idle) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != '0) begin
      tmo_cnt <= tmo_cnt - 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Timeout removes the tail first, then the output side pops the head, then a new ID is pushed.
  always_comb begin
    q0_n    = q0;
    q1_n    = q1;
    q_cnt_n = q_cnt;
    if (tmo_hit && q_cnt_n != 2'd0) q_cnt_n = q_cnt_n - 2'd1;
    if (pop && q_cnt_n != 2'd0) begin
      q0_n    = q1;
      q_cnt_n = q_cnt_n - 2'd1;
    end
    if (acc) begin
      if (q_cnt_n == 2'd0) q0_n = nxt;
      else                 q1_n = nxt;
      q_cnt_n = q_cnt_n + 2'd1;
    end
  end

  always_comb begin
    busy_n = busy;
    if (pop)     busy_n[out_sel] = 1'b0;
    if (tmo_hit) busy_n[eng_sel] = 1'b0;
    if (acc)     busy_n[nxt]     = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_state  <= IN_IDLE;
      out_state <= OUT_IDLE;
      nxt       <= 1'b0;
      q0        <= 1'b0;
      q1        <= 1'b0;
      q_cnt     <= 2'd0;
      busy      <= 2'b00;
      eng_sel   <= 1'b0;
      eng_sop   <= 2'b00;
      eng_valid <= 2'b00;
      eng_eop   <= 2'b00;
      err_drop  <= 1'b0;
      ord_err   <= 1'b0;
      tmo       <= 1'b0;
    end else begin
      q0        <= q0_n;
      q1        <= q1_n;
      q_cnt     <= q_cnt_n;
      busy      <= busy_n;
      err_drop  <= drop;
      ord_err   <= ord_ev;
      tmo       <= tmo_hit;
      eng_sop   <= acc ? onehot(nxt) : 2'b00;
      eng_valid <= (acc | fwd) ? onehot(tgt) : 2'b00;
      eng_eop   <= ((acc & in_eop) | fwd_eop) ? onehot(tgt) : 2'b00;

      if (acc) begin
        eng_sel <= nxt;
        nxt     <= ~nxt;
      end else if (tmo_hit) begin
        nxt     <= eng_sel;
      end

      // A single-beat packet (sop and eop together) never leaves IN_IDLE.
      case (in_state)
        IN_IDLE: if (acc && !in_eop)       in_state <= IN_FWD;
        IN_FWD:  if (fwd_eop || tmo_hit)   in_state <= IN_IDLE;
      endcase

      case (out_state)
        OUT_IDLE: if (h_sop && !h_eop)            out_state <= OUT_ACT;
        OUT_ACT:  if (h_eop || q_cnt_n == 2'd0)   out_state <= OUT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mrd_pkt_sched.sv
// Directed bench for mrd_pkt_sched: vector table plus hand sequences for
// back-to-back packets, mid-packet reset and the idle timeout.
module tb_mrd_pkt_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_sop, in_eop, in_valid;
  logic       in_ready;
  logic [1:0] eng_ready;
  logic [1:0] eng_sop, eng_valid, eng_eop;
  logic       eng_sel;
  logic [1:0] src_sop, src_eop;
  logic       out_sel;
  logic [1:0] busy;
  logic       err_drop, ord_err, tmo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mrd_pkt_sched #(.TMO_W(16), .TMO_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .in_sop(in_sop), .in_eop(in_eop), .in_valid(in_valid), .in_ready(in_ready),
    .eng_ready(eng_ready), .eng_sop(eng_sop), .eng_valid(eng_valid), .eng_eop(eng_eop),
    .eng_sel(eng_sel), .src_sop(src_sop), .src_eop(src_eop), .out_sel(out_sel),
    .busy(busy), .err_drop(err_drop), .ord_err(ord_err), .tmo(tmo)
  );

  typedef struct {
    logic [2:0] sev;   // {in_sop, in_eop, in_valid}
    logic [1:0] erdy, ssop, seop;
    logic       rdy;
    logic [1:0] esop, evld, eeop;
    logic       esel, osel;
    logic [1:0] bsy;
    logic       drop, oerr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [2:0] sev, input logic [1:0] erdy, ssop, seop,
                              input logic rdy, input logic [1:0] esop, evld, eeop,
                              input logic esel, osel, input logic [1:0] bsy,
                              input logic drop, oerr);
    vec_t v;
    v.sev = sev; v.erdy = erdy; v.ssop = ssop; v.seop = seop;
    v.rdy = rdy; v.esop = esop; v.evld = evld; v.eeop = eeop;
    v.esel = esel; v.osel = osel; v.bsy = bsy; v.drop = drop; v.oerr = oerr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %b required %b", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] sev, input logic [1:0] erdy, ssop, seop);
    {in_sop, in_eop, in_valid} = sev;
    eng_ready = erdy;
    src_sop   = ssop;
    src_eop   = seop;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".eng_sop"},   eng_sop,            2'b00);
    chk({tag, ".eng_valid"}, eng_valid,          2'b00);
    chk({tag, ".eng_eop"},   eng_eop,            2'b00);
    chk({tag, ".busy"},      busy,               2'b00);
    chk({tag, ".eng_sel"},   2'(eng_sel),        2'b00);
    chk({tag, ".out_sel"},   2'(out_sel),        2'b00);
    chk({tag, ".pulses"},    {err_drop, ord_err}, 2'b00);
    chk({tag, ".tmo"},       2'(tmo),            2'b00);
    chk({tag, ".in_ready"},  2'(in_ready),       2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(3'b000, 2'b11, 2'b00, 2'b00);

    // Reset state
    #1 rst = 1'b1;
    #2 chk_zero("rst_a");
    tick;
    chk_zero("rst_b");
    rst = 1'b0;
    #1 chk("rel.in_ready", 2'(in_ready), 2'b01);

    // Two back-to-back 16-beat packets: engine 0 then engine 1
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 16; k++) begin
        drive({(k == 0), (k == 15), 1'b1}, 2'b11, 2'b00, 2'b00);
        tick;
        chk($sformatf("b2b%0d_%0d.sop", p, k), eng_sop,   (k == 0)  ? (p == 0 ? 2'b01 : 2'b10) : 2'b00);
        chk($sformatf("b2b%0d_%0d.vld", p, k), eng_valid, (p == 0 ? 2'b01 : 2'b10));
        chk($sformatf("b2b%0d_%0d.eop", p, k), eng_eop,   (k == 15) ? (p == 0 ? 2'b01 : 2'b10) : 2'b00);
        chk($sformatf("b2b%0d_%0d.rdy", p, k), 2'(in_ready), 2'((k == 15) && (p == 0)));
      end
    end
    drive(3'b000, 2'b11, 2'b00, 2'b00);
    tick;
    chk("b2b.busy",    busy,          2'b11);
    chk("b2b.eng_sel", 2'(eng_sel),   2'b01);
    chk("b2b.out_sel", 2'(out_sel),   2'b00);

    // Queue {0,1}, both busy, nxt=0 at table start
    tbl.push_back(mk(3'b101, 2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0));
    tbl.push_back(mk(3'b000, 2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0));
    tbl.push_back(mk(3'b000, 2'b11, 2'b10, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1));
    tbl.push_back(mk(3'b000, 2'b11, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0));
    tbl.push_back(mk(3'b000, 2'b11, 2'b00, 2'b01, 1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0));
    tbl.push_back(mk(3'b000, 2'b11, 2'b10, 2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0));
    tbl.push_back(mk(3'b101, 2'b11, 2'b00, 2'b10, 1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0));
    tbl.push_back(mk(3'b011, 2'b11, 2'b00, 2'b00, 1'b1, 2'b00, 2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0));
    tbl.push_back(mk(3'b000, 2'b11, 2'b01, 2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0));
    tbl.push_back(mk(3'b101, 2'b11, 2'b00, 2'b01, 1'b0, 2'b10, 2'b10, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0));
    tbl.push_back(mk(3'b011, 2'b11, 2'b00, 2'b00, 1'b1, 2'b00, 2'b10, 2'b10, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0));
    tbl.push_back(mk(3'b000, 2'b11, 2'b01, 2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1));
    tbl.push_back(mk(3'b000, 2'b10, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0));
    tbl.push_back(mk(3'b101, 2'b10, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0));
    tbl.push_back(mk(3'b000, 2'b11, 2'b10, 2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0));
    tbl.push_back(mk(3'b000, 2'b11, 2'b00, 2'b10, 1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0));
    tbl.push_back(mk(3'b000, 2'b11, 2'b00, 2'b01, 1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1));
    tbl.push_back(mk(3'b111, 2'b11, 2'b00, 2'b00, 1'b1, 2'b01, 2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0));
    tbl.push_back(mk(3'b000, 2'b11, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0));
    tbl.push_back(mk(3'b101, 2'b11, 2'b00, 2'b00, 1'b0, 2'b10, 2'b10, 2'b00, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0));
    tbl.push_back(mk(3'b001, 2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 2'b10, 2'b00, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0));
    tbl.push_back(mk(3'b101, 2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0));
    tbl.push_back(mk(3'b011, 2'b11, 2'b00, 2'b00, 1'b0, 2'b00, 2'b10, 2'b10, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0));

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t t;
      t = tbl[i];
      drive(t.sev, t.erdy, t.ssop, t.seop);
      tick;
      chk($sformatf("v%0d.in_ready", i), 2'(in_ready), 2'(t.rdy));
      chk($sformatf("v%0d.eng_sop", i),  eng_sop,      t.esop);
      chk($sformatf("v%0d.eng_valid", i), eng_valid,   t.evld);
      chk($sformatf("v%0d.eng_eop", i),  eng_eop,      t.eeop);
      chk($sformatf("v%0d.eng_sel", i),  2'(eng_sel),  2'(t.esel));
      chk($sformatf("v%0d.out_sel", i),  2'(out_sel),  2'(t.osel));
      chk($sformatf("v%0d.busy", i),     busy,         t.bsy);
      chk($sformatf("v%0d.err_drop", i), 2'(err_drop), 2'(t.drop));
      chk($sformatf("v%0d.ord_err", i),  2'(ord_err),  2'(t.oerr));
    end

    // Reset in the middle of a packet: everything clears at once, the tail eop is not forwarded
    drive(3'b000, 2'b11, 2'b00, 2'b00);
    tick;
    rst = 1'b1;
    #2 rst = 1'b0;
    drive(3'b101, 2'b11, 2'b00, 2'b00);
    tick;
    chk("mid.sop", eng_sop, 2'b01);
    drive(3'b001, 2'b11, 2'b00, 2'b00);
    tick;
    chk("mid.vld", eng_valid, 2'b01);
    chk("mid.busy", busy, 2'b01);
    #3 rst = 1'b1;
    #1 chk_zero("mid_async");
    tick;
    chk_zero("mid_hold");
    drive(3'b011, 2'b11, 2'b00, 2'b00);
    rst = 1'b0;
    tick;
    chk("mid_tail.eop", eng_eop,   2'b00);
    chk("mid_tail.vld", eng_valid, 2'b00);
    drive(3'b000, 2'b11, 2'b00, 2'b00);
    tick;
    chk("mid_after.eop", eng_eop, 2'b00);

    // Idle timeout with TMO_MAX=8
    drive(3'b101, 2'b11, 2'b00, 2'b00);
    tick;
    chk("tmo.sop",  eng_sop, 2'b01);
    chk("tmo.busy", busy,    2'b01);
    drive(3'b000, 2'b11, 2'b00, 2'b00);
`ifdef MRD_SCHED_TIMEOUT_EN
    for (int i = 1; i <= 8; i++) begin
      tick;
      chk($sformatf("tmo.idle%0d", i), 2'(tmo), 2'(i == 8));
    end
    chk("tmo.busy_clr", busy,         2'b00);
    chk("tmo.in_ready", 2'(in_ready), 2'b01);
    tick;
    chk("tmo.one_pulse", 2'(tmo), 2'b00);
    drive(3'b111, 2'b11, 2'b00, 2'b00);
    tick;
    chk("tmo.nxt_eng0", eng_sop, 2'b01);
`else
    for (int i = 1; i <= 12; i++) begin
      tick;
      chk($sformatf("notmo.idle%0d", i), 2'(tmo), 2'b00);
    end
    chk("notmo.busy",     busy,         2'b01);
    chk("notmo.in_ready", 2'(in_ready), 2'b00);
    drive(3'b011, 2'b11, 2'b00, 2'b00);
    tick;
    chk("notmo.eop", eng_eop, 2'b01);
`endif
    drive(3'b000, 2'b11, 2'b00, 2'b00);
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
